// File: rtl/fft_result_collector.sv
// Captures one FFT output frame into a local buffer and serves it, plus CTRL/STATUS, on the data bus.
// Optional FFT_COLLECT_BITREV_EN stores sample j at bit-reversed index so the frame reads in natural order.
module fft_result_collector #(
  parameter int N_POINTS  = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en_i,
  input  logic [3:0]           we_i,
  input  logic [9:0]           addr_i,
  input  logic [31:0]          data_i,
  output logic [31:0]          data_o,
  input  logic                 out_valid_i,
  input  logic [OUT_WIDTH-1:0] dout_r_i,
  input  logic [OUT_WIDTH-1:0] dout_i_i,
  output logic                 irq_o
);

  localparam int          IDX_W    = $clog2(N_POINTS);
  localparam logic [7:0]  LAST_CNT = 8'(N_POINTS - 1);
  localparam logic [7:0]  N_WORDS  = 8'(N_POINTS);
  localparam logic [7:0]  BUF_BASE = 8'h40;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  count, count_next;
  logic        overrun, overrun_next;
  logic        irq_en, irq_en_next;
  logic [31:0] buffer [N_POINTS];

  logic [7:0]       word, buf_word;
  logic             bus_wr, bus_rd, ctrl_wr, arm, clear, store, last_store;
  logic [15:0]      ext_r, ext_i;
  logic [IDX_W-1:0] seq_idx, store_idx;
  logic [31:0]      rd_data;
  logic             unused_bits;

  assign word        = addr_i[9:2];
  assign buf_word    = word - BUF_BASE;
  assign bus_wr      = en_i & (we_i != 4'b0000);
  assign bus_rd      = en_i & (we_i == 4'b0000);
  assign ctrl_wr     = bus_wr & we_i[0] & (word == 8'd0);
  assign arm         = ctrl_wr & data_i[0];
  assign clear       = ctrl_wr & data_i[2];
  // ARM discards a coincident sample; completion outranks CLEAR below
  assign store       = out_valid_i & ~arm & ((state == S_ARMED) | (state == S_CAPTURE));
  assign last_store  = store & (count == LAST_CNT);
  assign seq_idx     = count[IDX_W-1:0];
  assign unused_bits = ^{addr_i[1:0], data_i[31:3]};

  always_comb begin
    ext_r = {16{dout_r_i[OUT_WIDTH-1]}};
    ext_i = {16{dout_i_i[OUT_WIDTH-1]}};
    ext_r[OUT_WIDTH-1:0] = dout_r_i;
    ext_i[OUT_WIDTH-1:0] = dout_i_i;
  end

`ifdef FFT_COLLECT_BITREV_EN
  always_comb begin
    store_idx = '0;
    for (int unsigned b = 0; b < IDX_W; b++) store_idx[b] = seq_idx[IDX_W-1-b];
  end
`else
  assign store_idx = seq_idx;
`endif

  always_comb begin
    state_next   = state;
    count_next   = count;
    overrun_next = overrun;
    irq_en_next  = irq_en;
    if (ctrl_wr) irq_en_next = data_i[1];
    if (arm) begin
      state_next   = S_ARMED;
      count_next   = '0;
      overrun_next = 1'b0;
    end else begin
      if (store) count_next = count + 8'd1;
      if (last_store)   state_next = S_DONE;
      else if (clear)   state_next = S_IDLE;
      else if (store)   state_next = S_CAPTURE;
      if (clear) overrun_next = 1'b0;
      else if ((state == S_DONE) && out_valid_i) overrun_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      count   <= '0;
      overrun <= 1'b0;
      irq_en  <= 1'b0;
      irq_o   <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      overrun <= overrun_next;
      irq_en  <= irq_en_next;
      irq_o   <= (state_next == S_DONE) & irq_en_next;
    end
  end

  always_ff @(posedge clk) begin
    if (store) buffer[store_idx] <= {ext_i, ext_r};
  end

  always_comb begin
    rd_data = '0;
    if (word == 8'd0)
      rd_data = {30'b0, irq_en, 1'b0};
    else if (word == 8'd1)
      rd_data = {16'b0, count, 5'b0, overrun, state == S_DONE,
                 (state == S_ARMED) | (state == S_CAPTURE)};
    else if ((word >= BUF_BASE) && (buf_word < N_WORDS))
      rd_data = buffer[buf_word[IDX_W-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    data_o <= '0;
    else if (bus_rd) data_o <= rd_data;
  end

endmodule
